layer_sequencer: RTL and testbench



---
 rtl/layer_seq_pkg.sv | 19 +
 rtl/seq_index_counter.sv | 43 ++++
 rtl/layer_sequencer.sv | 154 +++++++++++++++
 tb/tb_layer_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/layer_seq_pkg.sv
// Shared types and helpers for the layer sequencer.
// Holds the FSM state encoding and a width helper for index buses.
// No logic here; imported by the sequencer top.
package layer_seq_pkg;

    // Sequencer phases for one output: idle, clear accumulator, accumulate taps, present result.
    typedef enum logic [1:0] {
        eIDLE  = 2'd0,
        eCLEAR = 2'd1,
        eMAC   = 2'd2,
        eOUT   = 2'd3
    } seq_state_e;

    // Index bus width for a counter covering 0..n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_index_counter.sv
// Purpose: index counter 0..MAX-1 with synchronous clear, wraps to 0 after the last value.
// Latency: count updates one cycle after inc_i/clr_i; last_o is combinational from the count.
// Backpressure: none; the caller gates inc_i with its own handshake.
module seq_index_counter #(
    parameter int MAX   = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             last_o
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX - 1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear wins, otherwise step and return to 0 after the last index.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + WIDTH'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == LAST);

endmodule

// File: rtl/layer_sequencer.sv
// Purpose: sequences one FIR/CNN layer's MAC datapath (clear, K taps, present result) for every output.
// Latency: per output K+2 cycles with no stalls; done_o pulses the cycle after the last result handshake.
// Backpressure: valid_i low holds the tap index in eMAC; ready_i low holds valid_o/addr_o in eOUT.
// Optional: define LAYER_SEQ_PERF_EN to add a saturating stall counter output stall_cnt_o.
module layer_sequencer
    import layer_seq_pkg::*;
#(
    parameter int WORD_SIZE   = 16,
    parameter int KERNEL_SIZE = 3,
    parameter int OUTPUT_SIZE = 8
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 start_i,
    input  logic                                 valid_i,
    output logic                                 ready_o,
    output logic                                 mac_clear_o,
    output logic                                 mac_en_o,
    output logic [clog2_min1(KERNEL_SIZE)-1:0]   tap_o,
    output logic [WORD_SIZE-1:0]                 addr_o,
    output logic                                 valid_o,
    input  logic                                 ready_i,
    output logic                                 busy_o,
    output logic                                 done_o
`ifdef LAYER_SEQ_PERF_EN
    ,
    output logic [31:0]                          stall_cnt_o
`endif
);

    localparam int TAP_W = clog2_min1(KERNEL_SIZE);

    seq_state_e state_q;
    seq_state_e state_d;
    logic       done_q;
    logic       done_d;

    logic       start_acc;
    logic       sample_acc;
    logic       result_acc;
    logic       tap_last;
    logic       addr_last;

    logic [TAP_W-1:0]     tap_cnt;
    logic [WORD_SIZE-1:0] addr_cnt;

    assign start_acc  = (state_q == eIDLE) && start_i;
    assign sample_acc = (state_q == eMAC)  && valid_i;
    assign result_acc = (state_q == eOUT)  && ready_i;

    // Tap index: forced to 0 outside eMAC, steps on each accepted sample, wraps after the last tap.
    seq_index_counter #(
        .MAX   (KERNEL_SIZE),
        .WIDTH (TAP_W)
    ) u_tap_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (state_q != eMAC),
        .inc_i   (sample_acc),
        .cnt_o   (tap_cnt),
        .last_o  (tap_last)
    );

    // Output index: held at 0 while idle, steps on each result handshake, wraps after the last output.
    seq_index_counter #(
        .MAX   (OUTPUT_SIZE),
        .WIDTH (WORD_SIZE)
    ) u_addr_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (state_q == eIDLE),
        .inc_i   (result_acc),
        .cnt_o   (addr_cnt),
        .last_o  (addr_last)
    );

    // Next-state and done pulse decode; start_i is only honoured from eIDLE.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            eIDLE: begin
                if (start_i) begin
                    state_d = eCLEAR;
                end
            end
            eCLEAR: begin
                state_d = eMAC;
            end
            eMAC: begin
                if (valid_i && tap_last) begin
                    state_d = eOUT;
                end
            end
            eOUT: begin
                if (ready_i) begin
                    if (addr_last) begin
                        state_d = eIDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = eCLEAR;
                    end
                end
            end
            default: begin
                state_d = eIDLE;
            end
        endcase
    end

    // State and done registers; reset aborts any run without a done pulse.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= eIDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign ready_o     = (state_q == eMAC);
    assign mac_clear_o = (state_q == eCLEAR);
    assign mac_en_o    = sample_acc;
    assign valid_o     = (state_q == eOUT);
    assign busy_o      = (state_q != eIDLE);
    assign done_o      = done_q;
    assign tap_o       = tap_cnt;
    assign addr_o      = addr_cnt;

`ifdef LAYER_SEQ_PERF_EN
    logic [31:0] stall_q;
    logic        stall_evt;

    assign stall_evt = ((state_q == eMAC) && !valid_i) || ((state_q == eOUT) && !ready_i);

    // Stall counter: cleared by reset or an accepted start, saturates at all-ones, holds when idle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_q <= '0;
        end else if (start_acc) begin
            stall_q <= '0;
        end else if (stall_evt && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer with KERNEL_SIZE=3, OUTPUT_SIZE=4.
// A count-based model (active run, taps received, output index) is compared every cycle,
// and directed scenarios pin literal cycle numbers derived by hand.
module tb_layer_sequencer;

    localparam int K = 3;
    localparam int O = 4;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b0;
    logic        ready_o;
    logic        mac_clear_o;
    logic        mac_en_o;
    logic [1:0]  tap_o;
    logic [15:0] addr_o;
    logic        valid_o;
    logic        busy_o;
    logic        done_o;
`ifdef LAYER_SEQ_PERF_EN
    logic [31:0] stall_cnt_o;
`endif

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    layer_sequencer #(
        .WORD_SIZE   (16),
        .KERNEL_SIZE (K),
        .OUTPUT_SIZE (O)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .mac_clear_o (mac_clear_o),
        .mac_en_o    (mac_en_o),
        .tap_o       (tap_o),
        .addr_o      (addr_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o)
`ifdef LAYER_SEQ_PERF_EN
        ,
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_active  = 1'b0;
    bit          m_cleared = 1'b0;
    int          m_taps    = 0;
    int          m_out     = 0;
    bit          m_done    = 1'b0;
    int unsigned m_stall   = 0;

    always @(negedge clk_i) begin
        bit ph_idle, ph_clr, ph_mac, ph_out, nd;
        ph_idle = !m_active;
        ph_clr  = m_active && !m_cleared;
        ph_mac  = m_active && m_cleared && (m_taps < K);
        ph_out  = m_active && m_cleared && (m_taps == K);

        if (chk_en) begin
            chk("m_ready",  ready_o,     ph_mac);
            chk("m_clear",  mac_clear_o, ph_clr);
            chk("m_mac_en", mac_en_o,    ph_mac && valid_i);
            chk("m_tap",    tap_o,       ph_mac ? m_taps : 0);
            chk("m_addr",   addr_o,      m_active ? m_out : 0);
            chk("m_valid",  valid_o,     ph_out);
            chk("m_busy",   busy_o,      !ph_idle);
            chk("m_done",   done_o,      m_done);
`ifdef LAYER_SEQ_PERF_EN
            chk("m_stall",  stall_cnt_o, m_stall);
`endif
        end

        nd = 1'b0;
        if (reset_i) begin
            m_active = 0; m_cleared = 0; m_taps = 0; m_out = 0; m_stall = 0;
        end else if (ph_idle) begin
            if (start_i) begin
                m_active = 1; m_cleared = 0; m_taps = 0; m_out = 0; m_stall = 0;
            end
        end else if (ph_clr) begin
            m_cleared = 1;
        end else if (ph_mac) begin
            if (valid_i) m_taps++;
            else if (m_stall != 32'hFFFF_FFFF) m_stall++;
        end else if (ph_out) begin
            if (ready_i) begin
                if (m_out == O - 1) begin
                    m_active = 0; m_out = 0; nd = 1;
                end else begin
                    m_out++; m_cleared = 0; m_taps = 0;
                end
            end else if (m_stall != 32'hFFFF_FFFF) begin
                m_stall++;
            end
        end
        m_done = nd;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc_begin(input logic s, input logic v, input logic r, input logic rs);
        start_i = s; valid_i = v; ready_i = r; reset_i = rs;
        @(negedge clk_i);
    endtask

    task automatic cyc_end();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        cyc_begin(1'b0, 1'b0, 1'b0, 1'b1);
        cyc_end();
        cyc_begin(1'b0, 1'b1, 1'b1, 1'b0);
        chk("rst_busy",  busy_o, 0);
        chk("rst_tap",   tap_o, 0);
        chk("rst_addr",  addr_o, 0);
        chk("rst_done",  done_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_mac_en", mac_en_o, 0);
        cyc_end();
    endtask

    initial begin
        int ndone;
        cyc_begin(1'b0, 1'b0, 1'b0, 1'b1);
        cyc_end();
        chk_en = 1'b1;
        do_reset();

        // T1: clean run, all handshakes immediate.
        for (int c = 0; c < 23; c++) begin
            cyc_begin(c == 0, 1'b1, 1'b1, 1'b0);
            if (c == 1) chk("t1_clear_c1", mac_clear_o, 1);
            if (c == 2) chk("t1_tap_c2", tap_o, 0);
            if (c == 3) chk("t1_tap_c3", tap_o, 1);
            if (c == 4) chk("t1_tap_c4", tap_o, 2);
            if (c == 5) chk("t1_valid_c5", {valid_o, addr_o}, {1'b1, 16'd0});
            if (c == 10) chk("t1_valid_c10", {valid_o, addr_o}, {1'b1, 16'd1});
            if (c == 15) chk("t1_valid_c15", {valid_o, addr_o}, {1'b1, 16'd2});
            if (c == 20) chk("t1_valid_c20", {valid_o, addr_o}, {1'b1, 16'd3});
            chk("t1_done", done_o, c == 21);
            cyc_end();
        end

        // T2: valid_i low for two cycles while tap_o=1.
        for (int c = 0; c < 25; c++) begin
            cyc_begin(c == 0, !(c == 3 || c == 4), 1'b1, 1'b0);
            if (c == 3 || c == 4) chk("t2_tap_hold", {tap_o, mac_en_o}, {2'd1, 1'b0});
            if (c == 7) chk("t2_valid_c7", valid_o, 1);
            chk("t2_done", done_o, c == 23);
`ifdef LAYER_SEQ_PERF_EN
            if (c == 24) chk("t2_stall", stall_cnt_o, 2);
`endif
            cyc_end();
        end

        // T3: ready_i low for three cycles at addr_o=2.
        for (int c = 0; c < 26; c++) begin
            cyc_begin(c == 0, 1'b1, !(c >= 15 && c <= 17), 1'b0);
            if (c == 17) chk("t3_hold", {valid_o, addr_o}, {1'b1, 16'd2});
            if (c == 19) chk("t3_next", {mac_clear_o, addr_o}, {1'b1, 16'd3});
            chk("t3_done", done_o, c == 24);
`ifdef LAYER_SEQ_PERF_EN
            if (c == 25) chk("t3_stall", stall_cnt_o, 3);
`endif
            cyc_end();
        end

        // T4: start_i pulsed mid-run at addr_o=1 is ignored.
        ndone = 0;
        for (int c = 0; c < 24; c++) begin
            cyc_begin(c == 0 || c == 7 || c == 8, 1'b1, 1'b1, 1'b0);
            if (c == 9) chk("t4_ign", {tap_o, addr_o}, {2'd2, 16'd1});
            if (done_o) ndone++;
            cyc_end();
        end
        chk("t4_ndone", ndone, 1);

        // T5: reset in eMAC at tap_o=1, addr_o=2, then a fresh run.
        ndone = 0;
        for (int c = 0; c < 18; c++) begin
            cyc_begin(c == 0 || c == 15, 1'b1, 1'b1, c == 13);
            if (c == 13) chk("t5_pre", {tap_o, addr_o}, {2'd1, 16'd2});
            if (c == 14) chk("t5_abort", {busy_o, valid_o, ready_o, tap_o, addr_o}, 0);
            if (c == 16) chk("t5_restart", {mac_clear_o, addr_o}, {1'b1, 16'd0});
            if (done_o) ndone++;
            cyc_end();
        end
        chk("t5_ndone", ndone, 0);
        do_reset();

        // T6: start_i in the done_o cycle launches a second run.
        for (int c = 0; c < 24; c++) begin
            cyc_begin(c == 0 || c == 21, 1'b1, 1'b1, 1'b0);
            if (c == 21) chk("t6_done", done_o, 1);
            if (c == 22) chk("t6_clear", {mac_clear_o, busy_o, addr_o}, {1'b1, 1'b1, 16'd0});
            cyc_end();
        end
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
